// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, STATUS bit positions, TX FSM encoding and divisor floor for uart_tx_mmio.
package uart_pkg;
    localparam logic [1:0] REG_TXDATA   = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_BAUD_DIV = 2'd2;

    localparam int ST_BUSY   = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_EMPTY  = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_PARITY = 4;
    localparam int ST_COUNT  = 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [15:0] MIN_DIV = 16'd2;
endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// sync_fifo: single-clock FIFO; storage is not reset, only pointers and count.
// Ports: clk, reset (async active-low), push/push_data, pop/pop_data (head, valid when !empty),
//        full, empty, count (entries held).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    assign full     = count == FULL_CNT;
    assign empty    = count == '0;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with TX FIFO, STATUS and BAUD_DIV registers.
// Ports: clk; reset (async, active-low); memory_read/memory_write/address/write_data from the core;
//        read_data (registered load data, one-cycle latency); tx (serial line, idle high);
//        tx_irq (high while FIFO empty and FSM idle).
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h8000_0000,
    parameter int          CLK_FREQ     = 25_000_000,
    parameter int          BAUD_RATE    = 115_200,
    parameter int          FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        tx,
    output logic        tx_irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int RAW_DIV = CLK_FREQ / BAUD_RATE;
    localparam logic [15:0] RESET_DIV = (RAW_DIV < int'(MIN_DIV)) ? MIN_DIV : RAW_DIV[15:0];
`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    logic          sel, rd_en, wr_en, push, pop;
    logic [1:0]    off;
    logic          full, empty, overflow;
    logic [CW-1:0] count;
    logic [7:0]    fifo_data;
    logic [15:0]   baud_div;
    logic [31:0]   status;
    logic [2:0]    state, next_state;
    logic [7:0]    shift;
    logic [15:0]   div_l, baud_cnt;
    logic [2:0]    bit_cnt;
    logic          baud_done, tx_d;
    logic          unused;

    assign sel    = address[31:4] == BASE_ADDRESS[31:4];
    assign off    = address[3:2];
    assign rd_en  = memory_read && sel;
    assign wr_en  = memory_write && sel;
    assign push   = wr_en && off == REG_TXDATA;
    // Empty is the registered pre-edge value, so a freshly pushed byte pops a cycle later.
    assign pop    = state == S_IDLE && !empty;
    assign unused = ^{address[1:0], write_data[31:16]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (write_data[7:0]),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_comb begin
        status              = '0;
        status[ST_BUSY]     = state != S_IDLE;
        status[ST_FULL]     = full;
        status[ST_EMPTY]    = empty;
        status[ST_OVF]      = overflow;
        status[ST_PARITY]   = PARITY_EN;
        status[ST_COUNT+:8] = 8'(count);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data <= '0;
            overflow  <= 1'b0;
            baud_div  <= RESET_DIV;
        end else begin
            if (rd_en)
                read_data <= off == REG_STATUS   ? status :
                             off == REG_BAUD_DIV ? {16'h0, baud_div} : '0;
            if (push && full)
                overflow <= 1'b1;
            else if (wr_en && off == REG_STATUS && write_data[ST_OVF])
                overflow <= 1'b0;
            if (wr_en && off == REG_BAUD_DIV)
                baud_div <= write_data[15:0] < MIN_DIV ? MIN_DIV : write_data[15:0];
        end
    end

    assign baud_done = baud_cnt == div_l - 16'd1;

    // Shift register rotates rather than shifts so the full byte is still present for parity.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            shift    <= '0;
            div_l    <= MIN_DIV;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            state <= next_state;
            tx    <= tx_d;
            if (state == S_IDLE) begin
                if (!empty) begin
                    shift <= fifo_data;
                    div_l <= baud_div;
                end
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                baud_cnt <= baud_done ? '0 : baud_cnt + 16'd1;
                if (state == S_DATA && baud_done) begin
                    shift   <= {shift[0], shift[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   next_state = !empty ? S_START : S_IDLE;
            S_START:  next_state = baud_done ? S_DATA : S_START;
            S_DATA:   next_state = (baud_done && bit_cnt == 3'd7) ? (PARITY_EN ? S_PARITY : S_STOP) : S_DATA;
            S_PARITY: next_state = baud_done ? S_STOP : S_PARITY;
            S_STOP:   next_state = baud_done ? S_IDLE : S_STOP;
            default:  next_state = S_IDLE;
        endcase
    end

    // tx is computed for the state being entered so the registered line changes on entry.
    always_comb begin
        tx_irq = empty && state == S_IDLE;
        case (next_state)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = (state == S_DATA && baud_done) ? shift[1] : shift[0];
            S_PARITY: tx_d = ^shift;
            default:  tx_d = 1'b1;
        endcase
    end
endmodule
